// File: rtl/mv_decode_ctrl.sv
// mv_decode_ctrl: motion-vector decode sequencer.
// Runs one motion-code lookup per component, then pulls the residual bits
// and emits a signed delta per component.
// Optional feature macro: MV_PREDICT_EN (predictor registers + range-wrapped mv_out).
// Note: the bitstream window port is named bs_buf because "buf" is a reserved word.
module mv_decode_ctrl #(
    parameter int DW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 two_vec,
    input  logic [3:0]           f_code_fwd,
    input  logic [3:0]           f_code_bwd,
    input  logic [19:0]          bs_buf,
    input  logic                 bs_ready,
    output logic                 bs_adv,
    output logic [4:0]           bs_shift,
    output logic                 mc_req,
    input  logic                 mc_done,
    input  logic signed [5:0]    mc_value,
    input  logic [4:0]           mc_shift,
    input  logic                 mc_error,
    input  logic                 pmv_clr,
    output logic                 delta_valid,
    output logic signed [DW-1:0] delta,
    output logic signed [DW-1:0] mv_out,
    output logic [1:0]           comp_idx,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    typedef enum logic [3:0] {
        IDLE, CHECK, MC_REQ, MC_WAIT, MC_ADV, RES, RES_ADV, CALC, EMIT, FIN
    } state_t;

    state_t state, nxt;

    logic              two_q;
    logic [3:0]        fcf_q, fcb_q;
    logic signed [5:0] mc_q;
    logic [7:0]        res_q;
    logic              err_q;

    logic       adv_n, req_n, dv_n, done_n, err_n;
    logic [4:0] shift_n;
    logic       ld_cfg, ld_mc, ld_res, set_err, inc_idx;

    logic [3:0] r_size;
    logic [1:0] last_idx;
    logic       cfg_bad;
    logic [7:0] res_cap;

    // horizontal/vertical of the same vector share one f_code
    assign r_size   = comp_idx[1] ? (fcb_q - 4'd1) : (fcf_q - 4'd1);
    assign last_idx = two_q ? 2'd3 : 2'd1;
    assign cfg_bad  = (fcf_q == 4'd0) || (fcf_q > 4'd9) ||
                      (two_q && ((fcb_q == 4'd0) || (fcb_q > 4'd9)));
    // top r_size bits of the window, right-aligned (r_size is 1..8 here)
    assign res_cap  = bs_buf[19:12] >> (4'd8 - r_size);

    logic unused;

    // delta arithmetic; |delta| <= 4096 so 14-bit signed is enough
    logic signed [13:0] mc_ext, mc_abs, mag, d14;
    always_comb begin
        mc_ext = {{8{mc_q[5]}}, mc_q};
        mc_abs = mc_q[5] ? -mc_ext : mc_ext;
        mag    = ((mc_abs - 14'sd1) <<< r_size) + $signed({6'd0, res_q}) + 14'sd1;
        d14    = ((mc_q == 6'sd0) || (r_size == 4'd0)) ? mc_ext
               : (mc_q[5] ? -mag : mag);
    end

    // next-state and registered-output decode; every pulse is high while in its target state
    always_comb begin
        nxt     = state;
        adv_n   = 1'b0;
        shift_n = 5'd0;
        req_n   = 1'b0;
        dv_n    = 1'b0;
        done_n  = 1'b0;
        err_n   = 1'b0;
        ld_cfg  = 1'b0;
        ld_mc   = 1'b0;
        ld_res  = 1'b0;
        set_err = 1'b0;
        inc_idx = 1'b0;
        case (state)
            IDLE: if (start) begin
                nxt    = CHECK;
                ld_cfg = 1'b1;
            end
            CHECK: if (cfg_bad) begin
                nxt     = FIN;
                set_err = 1'b1;
                done_n  = 1'b1;
                err_n   = 1'b1;
            end else begin
                nxt = MC_REQ;
            end
            MC_REQ: if (bs_ready) begin
                nxt   = MC_WAIT;
                req_n = 1'b1;
            end
            MC_WAIT: if (mc_done) begin
                if (mc_error) begin
                    nxt     = FIN;
                    set_err = 1'b1;
                    done_n  = 1'b1;
                    err_n   = 1'b1;
                end else begin
                    nxt     = MC_ADV;
                    ld_mc   = 1'b1;
                    adv_n   = 1'b1;
                    shift_n = mc_shift;
                end
            end
            MC_ADV: nxt = ((r_size != 4'd0) && (mc_q != 6'sd0)) ? RES : CALC;
            RES: if (bs_ready) begin
                nxt     = RES_ADV;
                ld_res  = 1'b1;
                adv_n   = 1'b1;
                shift_n = {1'b0, r_size};
            end
            RES_ADV: nxt = CALC;
            CALC: begin
                nxt  = EMIT;
                dv_n = 1'b1;
            end
            EMIT: if (comp_idx == last_idx) begin
                nxt    = FIN;
                done_n = 1'b1;
                err_n  = err_q;
            end else begin
                nxt     = MC_REQ;
                inc_idx = 1'b1;
            end
            FIN:     nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // state, latched slot config and registered pulse outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            two_q       <= 1'b0;
            fcf_q       <= 4'd0;
            fcb_q       <= 4'd0;
            mc_q        <= 6'sd0;
            res_q       <= 8'd0;
            err_q       <= 1'b0;
            comp_idx    <= 2'd0;
            bs_adv      <= 1'b0;
            bs_shift    <= 5'd0;
            mc_req      <= 1'b0;
            delta_valid <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= nxt;
            bs_adv      <= adv_n;
            bs_shift    <= shift_n;
            mc_req      <= req_n;
            delta_valid <= dv_n;
            done        <= done_n;
            err         <= err_n;
            busy        <= (nxt != IDLE);
            if (ld_cfg) begin
                two_q    <= two_vec;
                fcf_q    <= f_code_fwd;
                fcb_q    <= f_code_bwd;
                comp_idx <= 2'd0;
                err_q    <= 1'b0;
            end
            if (set_err) err_q <= 1'b1;
            if (ld_mc)   mc_q  <= mc_value;
            if (ld_res)  res_q <= res_cap;
            if (inc_idx) comp_idx <= comp_idx + 2'd1;
        end
    end

    // delta is captured leaving CALC so it is stable during EMIT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)               delta <= '0;
        else if (state == CALC) delta <= {{(DW-14){d14[13]}}, d14};
    end

`ifdef MV_PREDICT_EN
    localparam logic signed [DW+1:0] RNG_BASE = {{(DW-3){1'b0}}, 5'b10000};

    logic signed [DW-1:0] pmv [4];
    logic signed [DW+1:0] pmv_ext, dlt_ext, sum, rng, v;

    assign unused = ^bs_buf[11:0];

    // predictor + delta, wrapped once into [-range, range-1]
    always_comb begin
        pmv_ext = {{2{pmv[comp_idx][DW-1]}}, pmv[comp_idx]};
        dlt_ext = {{(DW-12){d14[13]}}, d14};
        rng     = RNG_BASE <<< r_size;
        sum     = pmv_ext + dlt_ext;
        v       = sum;
        if (sum >= rng)       v = sum - (rng <<< 1);
        else if (sum < -rng)  v = sum + (rng <<< 1);
    end

    // predictors: cleared on request while idle, updated with each emitted vector
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) pmv[i] <= '0;
        end else if ((state == IDLE) && pmv_clr) begin
            for (int i = 0; i < 4; i++) pmv[i] <= '0;
        end else if (state == CALC) begin
            pmv[comp_idx] <= v[DW-1:0];
        end
    end

    // reconstructed vector, presented alongside delta
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)               mv_out <= '0;
        else if (state == CALC) mv_out <= v[DW-1:0];
    end
`else
    assign unused = ^{bs_buf[11:0], pmv_clr};
    assign mv_out = '0;
`endif

endmodule
